// File: rtl/dvd_pkg.sv
// Shared geometry, state encoding and palette width for the DVD sprite motion logic.
package dvd_pkg;
    localparam int X_W        = 5;
    localparam int Y_W        = 4;
    localparam int X_MAX      = 19;
    localparam int Y_MAX      = 14;
    localparam int CELL_SHIFT = 5;
    localparam int PAL_W      = 3;

    typedef enum logic {
        WAIT = 1'b0,
        STEP = 1'b1
    } state_t;
endpackage

// File: rtl/dvd_axis_bounce.sv
// Wall logic for one axis: computes the next position/direction and flags a bounce.
module dvd_axis_bounce #(
    parameter int W   = 5,
    parameter int MAX = 19
) (
    input  logic         en_i,
    input  logic [W-1:0] pos_i,
    input  logic         dir_i,
    output logic [W-1:0] pos_o,
    output logic         dir_o,
    output logic         bounce_o
);
    localparam logic [W-1:0] MAX_C = W'(MAX);

    // At a wall the position dwells for one step while the direction flips.
    always_comb begin
        pos_o    = pos_i;
        dir_o    = dir_i;
        bounce_o = 1'b0;
        if (en_i) begin
            if (dir_i && (pos_i == MAX_C)) begin
                dir_o    = 1'b0;
                bounce_o = 1'b1;
            end else if (!dir_i && (pos_i == '0)) begin
                dir_o    = 1'b1;
                bounce_o = 1'b1;
            end else if (dir_i) begin
                pos_o = pos_i + 1'b1;
            end else begin
                pos_o = pos_i - 1'b1;
            end
        end
    end
endmodule

// File: rtl/dvd_motion_scheduler.sv
// Frame-rate divided motion sequencer for the DVD sprite, running on the pixel clock.
// Handshake: there is none; step_o is a one-cycle strobe qualifying the freshly committed pos/dir.
module dvd_motion_scheduler #(
    parameter int X_W    = dvd_pkg::X_W,
    parameter int Y_W    = dvd_pkg::Y_W,
    parameter int X_MAX  = dvd_pkg::X_MAX,
    parameter int Y_MAX  = dvd_pkg::Y_MAX,
    parameter int X_INIT = 0,
    parameter int Y_INIT = 1,
    parameter int DIV_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] frame_div_i,
    input  logic             dir_x_init_i,
    input  logic             dir_y_init_i,
    output logic [X_W-1:0]   pos_x_o,
    output logic [Y_W-1:0]   pos_y_o,
    output logic             dir_x_o,
    output logic             dir_y_o,
    output logic             step_o,
    output logic             bounce_x_o,
    output logic             bounce_y_o,
    output logic             corner_o,
    output logic [2:0]       color_idx_o,
    output logic             dbg_state_o
);
    import dvd_pkg::*;

    state_t             state_q;
    logic               vs_q;
    logic [DIV_W-1:0]   frame_cnt_q;
    logic [X_W-1:0]     pos_x_q, pos_x_d;
    logic [Y_W-1:0]     pos_y_q, pos_y_d;
    logic               dir_x_q, dir_x_d;
    logic               dir_y_q, dir_y_d;
    logic               bounce_x_d, bounce_y_d;
    logic               step_q, bounce_x_q, bounce_y_q, corner_q;
    logic [PAL_W-1:0]   color_q;
    logic               tick;
    logic               in_step;

    assign tick    = vsync_i & ~vs_q;
    assign in_step = (state_q == STEP);

    dvd_axis_bounce #(.W(X_W), .MAX(X_MAX)) u_axis_x (
        .en_i     (in_step),
        .pos_i    (pos_x_q),
        .dir_i    (dir_x_q),
        .pos_o    (pos_x_d),
        .dir_o    (dir_x_d),
        .bounce_o (bounce_x_d)
    );

    dvd_axis_bounce #(.W(Y_W), .MAX(Y_MAX)) u_axis_y (
        .en_i     (in_step),
        .pos_i    (pos_y_q),
        .dir_i    (dir_y_q),
        .pos_o    (pos_y_d),
        .dir_o    (dir_y_d),
        .bounce_o (bounce_y_d)
    );

    // vs_q resets high so a vsync already high at reset release is not a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT;
            vs_q        <= 1'b1;
            frame_cnt_q <= '0;
            pos_x_q     <= X_W'(X_INIT);
            pos_y_q     <= Y_W'(Y_INIT);
            dir_x_q     <= dir_x_init_i;
            dir_y_q     <= dir_y_init_i;
            step_q      <= 1'b0;
            bounce_x_q  <= 1'b0;
            bounce_y_q  <= 1'b0;
            corner_q    <= 1'b0;
            color_q     <= '0;
        end else begin
            vs_q       <= vsync_i;
            step_q     <= 1'b0;
            bounce_x_q <= 1'b0;
            bounce_y_q <= 1'b0;
            corner_q   <= 1'b0;
            case (state_q)
                WAIT: begin
                    // >= lets a lowered divider take effect on the next frame.
                    if (tick && run_i) begin
                        if (frame_cnt_q >= frame_div_i) begin
                            frame_cnt_q <= '0;
                            state_q     <= STEP;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                STEP: begin
                    pos_x_q    <= pos_x_d;
                    pos_y_q    <= pos_y_d;
                    dir_x_q    <= dir_x_d;
                    dir_y_q    <= dir_y_d;
                    step_q     <= 1'b1;
                    bounce_x_q <= bounce_x_d;
                    bounce_y_q <= bounce_y_d;
                    corner_q   <= bounce_x_d & bounce_y_d;
                    if (bounce_x_d || bounce_y_d) begin
                        color_q <= color_q + 1'b1;
                    end
                    state_q <= WAIT;
                end
                default: state_q <= WAIT;
            endcase
        end
    end

    assign pos_x_o     = pos_x_q;
    assign pos_y_o     = pos_y_q;
    assign dir_x_o     = dir_x_q;
    assign dir_y_o     = dir_y_q;
    assign step_o      = step_q;
    assign bounce_x_o  = bounce_x_q;
    assign bounce_y_o  = bounce_y_q;
    assign corner_o    = corner_q;
    assign color_idx_o = color_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_dvd_motion_scheduler.sv
// Scoreboarded bench: two scheduler instances (default start and a (0,0) start that reaches a corner).
module tb_dvd_motion_scheduler;
    localparam int XM = 19;
    localparam int YM = 14;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync_i = 1'b1;
    logic       run_i = 1'b1;
    logic [3:0] frame_div_i = '0;
    logic       dir_x_init_i = 1'b1;
    logic       dir_y0_init = 1'b0;
    logic       dir_y1_init = 1'b1;

    logic [4:0] px0, px1;
    logic [3:0] py0, py1;
    logic       dx0, dy0, st0, bx0, by0, cr0, dbg0;
    logic       dx1, dy1, st1, bx1, by1, cr1, dbg1;
    logic [2:0] col0, col1;

    dvd_motion_scheduler u_dut0 (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .run_i(run_i),
        .frame_div_i(frame_div_i), .dir_x_init_i(dir_x_init_i), .dir_y_init_i(dir_y0_init),
        .pos_x_o(px0), .pos_y_o(py0), .dir_x_o(dx0), .dir_y_o(dy0), .step_o(st0),
        .bounce_x_o(bx0), .bounce_y_o(by0), .corner_o(cr0), .color_idx_o(col0),
        .dbg_state_o(dbg0)
    );

    dvd_motion_scheduler #(.Y_INIT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .run_i(run_i),
        .frame_div_i(frame_div_i), .dir_x_init_i(dir_x_init_i), .dir_y_init_i(dir_y1_init),
        .pos_x_o(px1), .pos_y_o(py1), .dir_x_o(dx1), .dir_y_o(dy1), .step_o(st1),
        .bounce_x_o(bx1), .bounce_y_o(by1), .corner_o(cr1), .color_idx_o(col1),
        .dbg_state_o(dbg1)
    );

    // clock/reset block
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [33:0] exp_q[$];
    int last_edge_cyc = 0;
    int seen_steps = 0;
    bit mon_en = 1'b0;
    bit prev_step = 1'b0;

    // reference model state, index 0/1 = instance
    int m_px[2], m_py[2], m_dx[2], m_dy[2], m_col[2];
    int m_cnt = 0;
    int m_steps = 0;
    int m_corners = 0;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] pack(input int px, input int py, input int dx, input int dy,
                                         input int bx, input int by, input int cr, input int col);
        logic [4:0] a;
        logic [3:0] b;
        logic [2:0] c;
        a = px[4:0];
        b = py[3:0];
        c = col[2:0];
        return {a, b, dx[0], dy[0], bx[0], by[0], cr[0], c};
    endfunction

    function automatic logic [33:0] observed();
        return {pack(int'(px0), int'(py0), int'(dx0), int'(dy0), int'(bx0), int'(by0), int'(cr0), int'(col0)),
                pack(int'(px1), int'(py1), int'(dx1), int'(dy1), int'(bx1), int'(by1), int'(cr1), int'(col1))};
    endfunction

    function automatic logic [33:0] model_rest();
        return {pack(m_px[0], m_py[0], m_dx[0], m_dy[0], 0, 0, 0, m_col[0]),
                pack(m_px[1], m_py[1], m_dx[1], m_dy[1], 0, 0, 0, m_col[1])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_px[i] = 0;
            m_dx[i] = int'(dir_x_init_i);
            m_col[i] = 0;
        end
        m_py[0] = 1;
        m_py[1] = 0;
        m_dy[0] = int'(dir_y0_init);
        m_dy[1] = int'(dir_y1_init);
        m_cnt = 0;
    endtask

    // Bounce rule: moving into a wall turns around without moving this step.
    task automatic axis_move(input int max, inout int p, inout int d, output int b);
        b = 0;
        if (d == 1 && p == max) begin d = 0; b = 1; end
        else if (d == 0 && p == 0) begin d = 1; b = 1; end
        else p = p + ((d == 1) ? 1 : -1);
    endtask

    task automatic model_step();
        logic [16:0] ent[2];
        int bxv, byv;
        for (int i = 0; i < 2; i++) begin
            axis_move(XM, m_px[i], m_dx[i], bxv);
            axis_move(YM, m_py[i], m_dy[i], byv);
            if (bxv != 0 || byv != 0) m_col[i] = (m_col[i] + 1) % 8;
            if (bxv != 0 && byv != 0) m_corners++;
            ent[i] = pack(m_px[i], m_py[i], m_dx[i], m_dy[i], bxv, byv, bxv & byv, m_col[i]);
        end
        m_steps++;
        exp_q.push_back({ent[0], ent[1]});
    endtask

    task automatic model_edge();
        if (run_i) begin
            if (m_cnt >= int'(frame_div_i)) begin
                m_cnt = 0;
                model_step();
            end else begin
                m_cnt++;
            end
        end
    endtask

    // driver tasks (called at a negedge)
    task automatic frame();
        vsync_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        vsync_i = 1'b1;
        last_edge_cyc = cyc;
        model_edge();
        repeat ($urandom_range(3, 5)) @(negedge clk);
    endtask

    task automatic do_reset(input logic vs);
        rst_n = 1'b0;
        vsync_i = vs;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            check("step_sync", 34'(st1), 34'(st0));
            if (st0) begin
                check("step_width", 34'(prev_step), 34'd0);
                if (exp_q.size() == 0) check("step_pending", 34'(exp_q.size()), 34'd1);
                else check("step_result", observed(), exp_q.pop_front());
                check("step_latency", 34'(cyc - last_edge_cyc), 34'd2);
                seen_steps++;
            end else begin
                check("no_stray_pulse", {28'd0, bx0, by0, cr0, bx1, by1, cr1}, 34'd0);
            end
            prev_step = st0;
        end
    end

    int s0;
    initial begin
        // reset with vsync held high across release
        @(negedge clk);
        do_reset(1'b1);
        mon_en = 1'b1;
        check("reset_state", observed(), model_rest());
        check("reset_state_raw0", {22'd0, px0, py0, dx0, dy0, col0}, {22'd0, 5'd0, 4'd1, 1'b1, 1'b0, 3'd0});
        repeat (6) @(negedge clk);
        check("no_step_vsync_high", 34'(seen_steps), 34'd0);

        // divide-by-1: three steps, y bounces off the top wall on the second
        frame_div_i = 4'd0;
        repeat (3) frame();
        check("after_3_steps", {25'd0, px0, py0}, {25'd0, 5'd3, 4'd1});

        // divide-by-3: one step per three frames
        frame_div_i = 4'd2;
        s0 = seen_steps;
        repeat (6) frame();
        check("div3_steps", 34'(seen_steps - s0), 34'd2);

        // lower the divider mid-count: step on the very next frame
        frame_div_i = 4'd3;
        s0 = seen_steps;
        repeat (2) frame();
        frame_div_i = 4'd0;
        frame();
        check("div_lowered_step", 34'(seen_steps - s0), 34'd1);

        // freeze for 10 frames, then resume at the programmed rate
        frame_div_i = 4'd2;
        frame();
        run_i = 1'b0;
        s0 = seen_steps;
        repeat (10) frame();
        check("frozen_steps", 34'(seen_steps - s0), 34'd0);
        check("frozen_pos", observed(), model_rest());
        run_i = 1'b1;
        frame();
        check("resume_count_kept", 34'(seen_steps - s0), 34'd0);
        frame();
        check("resume_step", 34'(seen_steps - s0), 34'd1);

        // random stretch until the (0,0) instance hits a corner
        for (int n = 0; n < 800 && !(m_corners > 0 && m_steps > 80); n++) begin
            frame_div_i = 4'($urandom_range(0, 1));
            run_i = ($urandom_range(0, 7) != 0);
            frame();
        end
        run_i = 1'b1;
        check("corner_reached", 34'(m_corners > 0), 34'd1);

        // reset asserted during the STEP cycle cancels the step
        frame_div_i = 4'd0;
        vsync_i = 1'b0;
        repeat (2) @(negedge clk);
        vsync_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        check("rst_in_step_nostep", 34'(st0), 34'd0);
        check("rst_in_step_state", observed(), model_rest());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (4) frame();

        // drain
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
        check("queue_drained", 34'(exp_q.size()), 34'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
